// File: rtl/am2940_word_ctrl.sv
// Am2940-style DMA instruction decoder and request/ack transfer sequencer driving word_path (and address path).
// Optional address-path control is enabled by defining AM2940_ADDR_CTRL_EN.
module am2940_word_ctrl #(
  parameter int INSTR_W = 3,
  parameter int DATA_W  = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  bus_data_in,
  input  logic [DATA_W-1:0]  word_count_in,
  input  logic               wco_in,
  input  logic               xfer_ack,
  output logic               plwr,
  output logic               selw,
  output logic               plwc,
  output logic               enw,
  output logic               incw,
  output logic               wci,
  output logic               plar,
  output logic               plac,
  output logic               ena,
  output logic               inca,
  output logic               aci,
  output logic [2:0]         ctrl_reg_out,
  output logic [1:0]         data_sel,
  output logic               data_oe,
  output logic               xfer_req,
  output logic               done
);

  localparam logic [INSTR_W-1:0] OP_WRCR   = INSTR_W'(0);
  localparam logic [INSTR_W-1:0] OP_RDCR   = INSTR_W'(1);
  localparam logic [INSTR_W-1:0] OP_RDWC   = INSTR_W'(2);
  localparam logic [INSTR_W-1:0] OP_RDAC   = INSTR_W'(3);
  localparam logic [INSTR_W-1:0] OP_REINIT = INSTR_W'(4);
  localparam logic [INSTR_W-1:0] OP_LDADDR = INSTR_W'(5);
  localparam logic [INSTR_W-1:0] OP_LDWC   = INSTR_W'(6);
  localparam logic [INSTR_W-1:0] OP_ENCT   = INSTR_W'(7);

`ifdef AM2940_ADDR_CTRL_EN
  localparam bit ADDR_EN = 1'b1;
`else
  localparam bit ADDR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ctrl_reg, ctrl_nxt;

  logic       d_plwr, d_selw, d_plwc, d_plar, d_plac, d_oe;
  logic [1:0] d_sel;
  logic       load;
  logic       count_ack;
  logic       mode_carry;
  logic       term;
  logic       unused_bus;

  assign unused_bus = ^bus_data_in;
  // Reserved modes 10/11 fall back to down-count.
  assign mode_carry = (ctrl_reg[1:0] == 2'b01);
  assign term       = mode_carry ? wco_in : (word_count_in == DATA_W'(1));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      ctrl_reg <= 3'b000;
    end else begin
      state    <= state_nxt;
      ctrl_reg <= ctrl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_nxt  = ctrl_reg;
    d_plwr    = 1'b0;
    d_selw    = 1'b0;
    d_plwc    = 1'b0;
    d_plar    = 1'b0;
    d_plac    = 1'b0;
    d_oe      = 1'b0;
    d_sel     = 2'b00;
    load      = 1'b0;
    count_ack = 1'b0;

    if (instr_valid) begin
      case (instr)
        OP_WRCR: begin
          if (state != COUNT) ctrl_nxt = bus_data_in[2:0];
        end
        OP_RDCR, OP_RDWC: begin
          d_oe  = 1'b1;
          d_sel = instr[1:0];
        end
        OP_RDAC: begin
          d_oe  = ADDR_EN;
          d_sel = ADDR_EN ? instr[1:0] : 2'b00;
        end
        OP_REINIT: begin
          d_plwc    = 1'b1;
          d_selw    = 1'b1;
          d_plac    = ADDR_EN;
          load      = 1'b1;
          state_nxt = IDLE;
        end
        OP_LDADDR: begin
          if (ADDR_EN) begin
            d_plar = 1'b1;
            d_plac = 1'b1;
            load   = 1'b1;
            // DONE is only released by REINIT or LDWC.
            if (state != DONE) state_nxt = IDLE;
          end
        end
        OP_LDWC: begin
          d_plwr    = 1'b1;
          d_plwc    = 1'b1;
          load      = 1'b1;
          state_nxt = IDLE;
        end
        OP_ENCT: begin
          if (state == IDLE) begin
            if (!mode_carry && (word_count_in == '0)) state_nxt = DONE;
            else                                      state_nxt = COUNT;
          end
        end
        default: ;
      endcase
    end

    // A concurrent load owns the counters, so the ack is dropped.
    if (state == COUNT && xfer_ack && !load) begin
      count_ack = 1'b1;
      if (term) state_nxt = DONE;
    end
  end

  assign plwr         = res & d_plwr;
  assign selw         = res & d_selw;
  assign plwc         = res & d_plwc;
  assign enw          = res & (state == COUNT);
  assign incw         = res & mode_carry;
  assign wci          = res & count_ack;
  assign ctrl_reg_out = res ? ctrl_reg : 3'b000;
  assign data_oe      = res & d_oe;
  assign data_sel     = res ? d_sel : 2'b00;
  assign xfer_req     = res & (state == COUNT);
  assign done         = res & (state == DONE);

`ifdef AM2940_ADDR_CTRL_EN
  assign plar = res & d_plar;
  assign plac = res & d_plac;
  assign ena  = res & (state == COUNT);
  assign inca = res & (state == COUNT) & ctrl_reg[2];
  assign aci  = res & count_ack;
`else
  logic unused_addr;
  assign unused_addr = d_plar | d_plac;
  assign plar = 1'b0;
  assign plac = 1'b0;
  assign ena  = 1'b0;
  assign inca = 1'b0;
  assign aci  = 1'b0;
`endif

endmodule

// File: tb/tb_am2940_word_ctrl.sv
// Directed bench for am2940_word_ctrl with a small word_path stand-in (counter + word register).
module tb_am2940_word_ctrl;

`ifdef AM2940_ADDR_CTRL_EN
  localparam bit A = 1'b1;
`else
  localparam bit A = 1'b0;
`endif

  localparam logic [2:0] WRCR = 3'd0, RDCR = 3'd1, RDWC = 3'd2, RDAC = 3'd3,
                         REINIT = 3'd4, LDADDR = 3'd5, LDWC = 3'd6, ENCT = 3'd7;

  logic       clk = 1'b0;
  logic       res;
  logic       instr_valid;
  logic [2:0] instr;
  logic [3:0] bus_data_in, word_count_in;
  logic       wco_in, xfer_ack;
  logic       plwr, selw, plwc, enw, incw, wci, plar, plac, ena, inca, aci;
  logic [2:0] ctrl_reg_out;
  logic [1:0] data_sel;
  logic       data_oe, xfer_req, done;

  am2940_word_ctrl #(.INSTR_W(3), .DATA_W(4)) dut (
    .clk(clk), .res(res), .instr_valid(instr_valid), .instr(instr),
    .bus_data_in(bus_data_in), .word_count_in(word_count_in), .wco_in(wco_in),
    .xfer_ack(xfer_ack), .plwr(plwr), .selw(selw), .plwc(plwc), .enw(enw),
    .incw(incw), .wci(wci), .plar(plar), .plac(plac), .ena(ena), .inca(inca),
    .aci(aci), .ctrl_reg_out(ctrl_reg_out), .data_sel(data_sel),
    .data_oe(data_oe), .xfer_req(xfer_req), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] cnt, wreg;
  logic       c_plwr, c_selw, c_plwc, c_enw, c_incw, c_wci, c_plar, c_plac, c_ena, c_inca, c_aci, c_oe;
  logic [1:0] c_sel;

  typedef struct {
    logic       iv;
    logic [2:0] ins;
    logic [3:0] bus;
    logic [4:0] ld;    // {plwr, selw, plwc, plar, plac}
    logic       oe;
    logic [1:0] sel;
    logic [2:0] ctrl;  // ctrl_reg_out after the edge
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at edge+1, capture decode at negedge, advance the word_path stand-in at posedge.
  task automatic step(input logic iv, input logic [2:0] ins, input logic [3:0] bus, input logic ack);
    logic [3:0] wold;
    instr_valid   = iv;
    instr         = ins;
    bus_data_in   = bus;
    xfer_ack      = ack;
    word_count_in = cnt;
    wco_in        = (cnt == 4'hF);
    @(negedge clk);
    c_plwr = plwr; c_selw = selw; c_plwc = plwc; c_enw = enw; c_incw = incw; c_wci = wci;
    c_plar = plar; c_plac = plac; c_ena = ena; c_inca = inca; c_aci = aci;
    c_oe = data_oe; c_sel = data_sel;
    @(posedge clk);
    wold = wreg;
    if (c_plwr) wreg = bus;
    if (c_plwc)     cnt = c_selw ? wold : bus;
    else if (c_wci) cnt = c_incw ? cnt + 4'd1 : cnt - 4'd1;
    #1;
    word_count_in = cnt;
    wco_in        = (cnt == 4'hF);
  endtask

  task automatic run_acks(input int budget, output int pulses);
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, WRCR, 4'h0, 1'b1);
      if (c_wci) pulses++;
      if (done) break;
    end
  endtask

  function automatic logic [18:0] all_out();
    return {plwr, selw, plwc, enw, incw, wci, plar, plac, ena, inca, aci,
            ctrl_reg_out, data_sel, data_oe, xfer_req, done};
  endfunction

  initial begin
    int p;
    logic seen_req;
    vt[0] = '{1'b0, WRCR,   4'h7, 5'b00000,       1'b0, 2'b00,           3'b000};
    vt[1] = '{1'b1, WRCR,   4'h5, 5'b00000,       1'b0, 2'b00,           3'b101};
    vt[2] = '{1'b1, RDCR,   4'h0, 5'b00000,       1'b1, 2'b01,           3'b101};
    vt[3] = '{1'b1, RDWC,   4'h0, 5'b00000,       1'b1, 2'b10,           3'b101};
    vt[4] = '{1'b1, RDAC,   4'h0, 5'b00000,       A,    A ? 2'b11 : 2'b00, 3'b101};
    vt[5] = '{1'b1, REINIT, 4'h0, {4'b0110, A},   1'b0, 2'b00,           3'b101};
    vt[6] = '{1'b1, LDADDR, 4'h0, {3'b000, A, A}, 1'b0, 2'b00,           3'b101};
    vt[7] = '{1'b1, LDWC,   4'h6, 5'b10100,       1'b0, 2'b00,           3'b101};
    vt[8] = '{1'b1, WRCR,   4'h8, 5'b00000,       1'b0, 2'b00,           3'b000};

    cnt = 4'h0; wreg = 4'h0;
    res = 1'b0; instr_valid = 1'b1; instr = LDWC; bus_data_in = 4'hF; xfer_ack = 1'b1;
    word_count_in = 4'h0; wco_in = 1'b0;
    #2 chk("reset_outputs", all_out(), '0);
    @(negedge clk) res = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk) #1;

    // Single-cycle decode in IDLE, with ack held high to show it is ignored outside COUNT.
    for (int i = 0; i < 9; i++) begin
      step(vt[i].iv, vt[i].ins, vt[i].bus, 1'b1);
      chk($sformatf("vec%0d_loads", i), {c_plwr, c_selw, c_plwc, c_plar, c_plac}, vt[i].ld);
      chk($sformatf("vec%0d_oe_sel", i), {c_oe, c_sel}, {vt[i].oe, vt[i].sel});
      chk($sformatf("vec%0d_wci", i), {c_wci, c_aci, c_enw}, 3'b000);
      chk($sformatf("vec%0d_ctrl", i), ctrl_reg_out, vt[i].ctrl);
      chk($sformatf("vec%0d_req_done", i), {xfer_req, done}, 2'b00);
    end

    // Down-count of 6.
    step(1'b1, LDWC, 4'h6, 1'b0);
    chk("m0_ldwc_pulses", {c_plwr, c_plwc, c_selw}, 3'b110);
    step(1'b1, ENCT, 4'h0, 1'b0);
    chk("m0_req_after_enct", {xfer_req, done}, 2'b10);
    run_acks(40, p);
    chk("m0_wci_pulses", p, 6);
    chk("m0_done_noreq", {xfer_req, done}, 2'b01);
    step(1'b1, RDWC, 4'h0, 1'b1);
    chk("m0_rdwc", {c_oe, c_sel}, 3'b110);
    chk("m0_count_zero", word_count_in, 4'h0);

    // Carry mode from 0xD.
    step(1'b1, WRCR, 4'h1, 1'b0);
    chk("m1_ctrl", {ctrl_reg_out, incw}, 4'b0011);
    step(1'b1, LDWC, 4'hD, 1'b0);
    chk("m1_done_cleared", done, 1'b0);
    step(1'b1, ENCT, 4'h0, 1'b0);
    chk("m1_req", xfer_req, 1'b1);
    run_acks(40, p);
    chk("m1_wci_pulses", p, 3);
    chk("m1_done_noreq", {xfer_req, done}, 2'b01);
    chk("m1_count_zero", word_count_in, 4'h0);

    // Zero-length transfer.
    step(1'b1, WRCR, 4'h0, 1'b0);
    step(1'b1, LDWC, 4'h0, 1'b0);
    step(1'b1, ENCT, 4'h0, 1'b0);
    chk("zl_done", {xfer_req, done}, 2'b01);
    seen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, WRCR, 4'h0, 1'b1);
      seen_req = seen_req | xfer_req | c_wci;
    end
    chk("zl_no_req", seen_req, 1'b0);

    // Load colliding with ack, then WRCR during COUNT.
    step(1'b1, LDWC, 4'h5, 1'b0);
    step(1'b1, ENCT, 4'h0, 1'b0);
    step(1'b0, WRCR, 4'h0, 1'b1);
    chk("col_first_ack", {c_wci, c_enw, c_ena, c_aci}, {2'b11, A, A});
    step(1'b1, LDWC, 4'h9, 1'b1);
    chk("col_ack_dropped", {c_wci, c_aci, c_plwc}, 3'b001);
    chk("col_state_idle", {xfer_req, done}, 2'b00);
    chk("col_count_loaded", word_count_in, 4'h9);
    step(1'b1, ENCT, 4'h0, 1'b0);
    step(1'b1, WRCR, 4'h1, 1'b0);
    chk("col_wrcr_ignored", {ctrl_reg_out, xfer_req}, 4'b0001);
    run_acks(40, p);
    chk("col_wci_pulses", p, 9);
    chk("col_done", done, 1'b1);

    // REINIT from DONE, restart in carry/increment-address mode.
    step(1'b1, WRCR, 4'h5, 1'b0);
    chk("ri_ctrl", ctrl_reg_out, 3'b101);
    step(1'b1, REINIT, 4'h0, 1'b0);
    chk("ri_pulses", {c_plwc, c_selw, c_plwr, c_plac}, {3'b110, A});
    chk("ri_done_cleared", {xfer_req, done}, 2'b00);
    chk("ri_count_from_wreg", word_count_in, 4'h9);
    step(1'b1, ENCT, 4'h0, 1'b0);
    chk("ri_restart", {xfer_req, done}, 2'b10);
    step(1'b0, WRCR, 4'h0, 1'b1);
    chk("ri_count_step", {c_wci, c_incw, c_inca}, {2'b11, A});

    // Reset mid-COUNT with an instruction and ack presented.
    instr_valid = 1'b1; instr = LDWC; bus_data_in = 4'hF; xfer_ack = 1'b1;
    res = 1'b0;
    #2 chk("rst_mid_count", all_out(), '0);
    @(posedge clk) #1;
    chk("rst_held", all_out(), '0);
    @(negedge clk) res = 1'b1;
    instr_valid = 1'b0; xfer_ack = 1'b0;
    @(posedge clk) #1;
    chk("rst_release", {ctrl_reg_out, xfer_req, done}, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
